// File: rtl/win_banner_ctrl.sv
// WIN banner sequencer: slide banner to rest, hold (optionally blinking), then request level advance.
// Latency: all outputs registered, one cycle after the triggering input; REQ waits indefinitely for ack.
// Optional blinking during HOLD is enabled by defining WIN_BANNER_BLINK_EN.
module win_banner_ctrl #(
   parameter int unsigned TARGET_X    = 295,
   parameter int unsigned TARGET_Y    = 215,
   parameter int unsigned START_Y     = 0,
   parameter int unsigned SLIDE_STEP  = 4,
   parameter int unsigned HOLD_FRAMES = 120,
   parameter int unsigned BLINK_HALF  = 8
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        level_won,
   input  logic        skip,
   input  logic        next_level_ack,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic        banner_visible,
   output logic        next_level_req,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SLIDE,
      ST_HOLD,
      ST_REQ
   } state_t;

   localparam int unsigned CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
   localparam logic [10:0] TX     = 11'(TARGET_X);
   localparam logic [10:0] TY     = 11'(TARGET_Y);
   localparam logic [10:0] SY     = 11'(START_Y);
   localparam logic [11:0] STEP12 = 12'(SLIDE_STEP);
   localparam logic [11:0] TY12   = 12'(TARGET_Y);

   state_t           state_q, state_d;
   logic [10:0]      x_q, x_d;
   logic [10:0]      y_q, y_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             vis_q, vis_d;
   logic             req_q, req_d;
   logic             busy_q, busy_d;
   logic [11:0]      y_sum;
   logic             hold_vis;

`ifdef WIN_BANNER_BLINK_EN
   localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;
`endif

   always_comb begin
      state_d     = state_q;
      x_d         = TX;
      y_d         = y_q;
      frame_cnt_d = frame_cnt_q;
      // 12-bit sum so a large step near the bottom cannot wrap past TARGET_Y
      y_sum       = {1'b0, y_q} + STEP12;
`ifdef WIN_BANNER_BLINK_EN
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (level_won) begin
               state_d = ST_SLIDE;
               y_d     = SY;
            end
         end
         ST_SLIDE: begin
            if (skip || (startOfFrame && (y_sum >= TY12))) begin
               state_d     = ST_HOLD;
               y_d         = TY;
               frame_cnt_d = '0;
`ifdef WIN_BANNER_BLINK_EN
               blink_cnt_d = '0;
               phase_d     = 1'b1;
`endif
            end else if (startOfFrame) begin
               y_d = y_sum[10:0];
            end
         end
         ST_HOLD: begin
            if (skip) begin
               state_d = ST_REQ;
            end else if (startOfFrame) begin
               if (frame_cnt_q == HOLD_LAST) begin
                  state_d = ST_REQ;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
`ifdef WIN_BANNER_BLINK_EN
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  phase_d     = ~phase_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + 1'b1;
               end
`endif
            end
         end
         ST_REQ: begin
            if (next_level_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef WIN_BANNER_BLINK_EN
      hold_vis = phase_d;
`else
      hold_vis = 1'b1;
`endif

      // outputs are derived from the next state so they are registered alongside it
      case (state_d)
         ST_IDLE:  vis_d = 1'b0;
         ST_HOLD:  vis_d = hold_vis;
         default:  vis_d = 1'b1;
      endcase
      req_d  = (state_d == ST_REQ);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q     <= ST_IDLE;
         x_q         <= TX;
         y_q         <= SY;
         frame_cnt_q <= '0;
         vis_q       <= 1'b0;
         req_q       <= 1'b0;
         busy_q      <= 1'b0;
`ifdef WIN_BANNER_BLINK_EN
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         frame_cnt_q <= frame_cnt_d;
         vis_q       <= vis_d;
         req_q       <= req_d;
         busy_q      <= busy_d;
`ifdef WIN_BANNER_BLINK_EN
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
`endif
      end
   end

   assign topLeftX       = x_q;
   assign topLeftY       = y_q;
   assign banner_visible = vis_q;
   assign next_level_req = req_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Directed bench for win_banner_ctrl with default parameters (table vectors plus multi-cycle sequences).
module tb_win_banner_ctrl;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        level_won = 1'b0;
   logic        skip = 1'b0;
   logic        next_level_ack = 1'b0;
   logic [10:0] topLeftX;
   logic [10:0] topLeftY;
   logic        banner_visible;
   logic        next_level_req;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   win_banner_ctrl dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .level_won     (level_won),
      .skip          (skip),
      .next_level_ack(next_level_ack),
      .topLeftX      (topLeftX),
      .topLeftY      (topLeftY),
      .banner_visible(banner_visible),
      .next_level_req(next_level_req),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        sof;
      logic        won;
      logic        sk;
      logic        ack;
      logic        chk_y;
      logic [10:0] exp_y;
      logic        exp_vis;
      logic        exp_req;
      logic        exp_busy;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, clock edge, settle, then return inputs to idle.
   task automatic cyc(input logic r, input logic sof, input logic won, input logic sk, input logic ak);
      resetN = r; startOfFrame = sof; level_won = won; skip = sk; next_level_ack = ak;
      @(posedge clk);
      #1;
      resetN = 1'b0; startOfFrame = 1'b0; level_won = 1'b0; skip = 1'b0; next_level_ack = 1'b0;
   endtask

   function automatic logic hold_vis_exp(input int f);
`ifdef WIN_BANNER_BLINK_EN
      return ((f / 8) % 2) == 0;
`else
      return 1'b1;
`endif
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[15];
      int   exp_y;

      //         rst  sof  won  sk   ack  chky y    vis  req  busy
      vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,11'd0,  1'b0,1'b0,1'b0};
      vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,11'd0,  1'b0,1'b0,1'b0};
      vt[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,11'd0,  1'b0,1'b0,1'b0};
      vt[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,11'd0,  1'b1,1'b0,1'b1};
      vt[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,11'd4,  1'b1,1'b0,1'b1};
      vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,11'd4,  1'b1,1'b0,1'b1};
      vt[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,11'd8,  1'b1,1'b0,1'b1};
      vt[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,11'd8,  1'b1,1'b0,1'b1};
      vt[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,11'd215,1'b1,1'b0,1'b1};
      vt[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,11'd215,1'b1,1'b0,1'b1};
      vt[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,11'd215,1'b1,1'b1,1'b1};
      vt[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,11'd215,1'b1,1'b1,1'b1};
      vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,11'd0,  1'b0,1'b0,1'b0};
      vt[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,11'd0,  1'b1,1'b0,1'b1};
      vt[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,11'd0,  1'b0,1'b0,1'b0};

      resetN = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 15; i++) begin
         cyc(vt[i].rst, vt[i].sof, vt[i].won, vt[i].sk, vt[i].ack);
         if (vt[i].chk_y) chk($sformatf("vec%0d y", i), int'(topLeftY), int'(vt[i].exp_y));
         chk($sformatf("vec%0d vis", i), int'(banner_visible), int'(vt[i].exp_vis));
         chk($sformatf("vec%0d req", i), int'(next_level_req), int'(vt[i].exp_req));
         chk($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].exp_busy));
         chk($sformatf("vec%0d x", i), int'(topLeftX), 295);
      end

      // Nominal run: 54 slide frames, 120 hold frames, long-delayed ack.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("won busy", int'(busy), 1);
      chk("won vis", int'(banner_visible), 1);
      chk("won y", int'(topLeftY), 0);
      for (int k = 1; k <= 54; k++) begin
         cyc(0, 1, 0, 0, 0);
         exp_y = (4 * k >= 215) ? 215 : 4 * k;
         chk($sformatf("slide y frame %0d", k), int'(topLeftY), exp_y);
         chk($sformatf("slide vis frame %0d", k), int'(banner_visible), 1);
         cyc(0, 0, 0, 0, 0);
         chk($sformatf("slide y hold-between %0d", k), int'(topLeftY), exp_y);
      end
      for (int f = 1; f <= 120; f++) begin
         cyc(0, 1, 0, 0, 0);
         chk($sformatf("hold req frame %0d", f), int'(next_level_req), (f == 120) ? 1 : 0);
         chk($sformatf("hold vis frame %0d", f), int'(banner_visible),
             (f == 120) ? 1 : int'(hold_vis_exp(f)));
         chk($sformatf("hold y frame %0d", f), int'(topLeftY), 215);
         cyc(0, 0, 0, 0, 0);
      end
      for (int c = 0; c < 500; c++) begin
         cyc(0, c % 7 == 0, 0, c % 11 == 0, 0);
         chk("delayed ack req", int'(next_level_req), 1);
         chk("delayed ack vis", int'(banner_visible), 1);
      end
      cyc(0, 0, 0, 0, 1);
      chk("ack req", int'(next_level_req), 0);
      chk("ack busy", int'(busy), 0);
      chk("ack vis", int'(banner_visible), 0);
      cyc(0, 1, 0, 0, 0);
      chk("post-ack idle busy", int'(busy), 0);

      // Skip at Y=40, skip again in HOLD, then reset drops the request.
      cyc(0, 0, 1, 0, 0);
      for (int k = 1; k <= 10; k++) cyc(0, 1, 0, 0, 0);
      chk("skip pre y", int'(topLeftY), 40);
      cyc(0, 0, 0, 1, 0);
      chk("skip slide y", int'(topLeftY), 215);
      chk("skip slide req", int'(next_level_req), 0);
      chk("skip slide busy", int'(busy), 1);
      cyc(0, 0, 0, 1, 0);
      chk("skip hold req", int'(next_level_req), 1);
      cyc(1, 0, 0, 0, 0);
      chk("rst in req req", int'(next_level_req), 0);
      chk("rst in req busy", int'(busy), 0);

      // Reset mid-HOLD.
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);
      chk("pre-rst hold busy", int'(busy), 1);
      cyc(1, 0, 0, 0, 0);
      chk("rst hold y", int'(topLeftY), 0);
      chk("rst hold vis", int'(banner_visible), 0);
      chk("rst hold busy", int'(busy), 0);
      chk("rst hold req", int'(next_level_req), 0);
      chk("rst hold x", int'(topLeftX), 295);
      cyc(0, 1, 0, 0, 0);
      chk("after rst idle busy", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/win_banner_ctrl.md
# win_banner_ctrl

Sequencer for the 50×20 "WIN" banner bitmap. When a level is won, it slides the banner top-left position down the screen to its rest point, holds it there for a fixed number of frames (optionally blinking), then runs a request/acknowledge handshake with the game-state logic to advance the level. It sits between the game-state FSM and the banner's square-object/bitmap pair. It drives the banner's `topLeftX`/`topLeftY` and a visibility gate that is ANDed into the bitmap's `InsideRectangle`.

## Interface
Parameters:
- `TARGET_X`, 295: banner rest X (11-bit, pixels).
- `TARGET_Y`, 215: banner rest Y (11-bit).
- `START_Y`, 0: banner Y at slide start.
- `SLIDE_STEP`, 4: Y increment per frame during the slide.
- `HOLD_FRAMES`, 120: frames spent in HOLD; must be ≥1.
- `BLINK_HALF`, 8: frames per blink half-period; must be ≥1.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: synchronous, active-high reset (asserted = 1).
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `level_won` in 1: one-cycle pulse from game FSM.
- `skip` in 1: level-sensitive player key.
- `next_level_ack` in 1: game FSM acknowledge.
- `topLeftX` out 11: banner X.
- `topLeftY` out 11: banner Y.
- `banner_visible` out 1: gate for the bitmap `InsideRectangle`.
- `next_level_req` out 1: level-advance request.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, SLIDE, HOLD, REQ. All outputs are registered.
- IDLE: `banner_visible`=0 and `next_level_req`=0. A `level_won` pulse loads `topLeftY`=START_Y and `topLeftX`=TARGET_X, then moves to SLIDE.
- SLIDE, on each `startOfFrame`:
  - If `topLeftY + SLIDE_STEP >= TARGET_Y`: set `topLeftY`=TARGET_Y, clear the frame counter, set the blink phase to 1, and go to HOLD.
  - Otherwise: `topLeftY += SLIDE_STEP`.
  - The comparison uses 12-bit arithmetic so it cannot wrap.
- HOLD, on each `startOfFrame`:
  - If `frame_cnt == HOLD_FRAMES-1`: go to REQ.
  - Otherwise: increment `frame_cnt`.
- REQ: `next_level_req`=1 and is held until `next_level_ack`=1 is sampled. Next state is IDLE with `next_level_req`=0. `banner_visible` stays 1 in REQ.
- `skip`=1:
  - In SLIDE: immediately snap `topLeftY`=TARGET_Y and enter HOLD. This is not frame-aligned.
  - In HOLD: go to REQ on the next cycle.
  - In IDLE or REQ: ignored.
- `level_won` outside IDLE is ignored; it is not queued.
- `next_level_ack` outside REQ is ignored.
- Simultaneous events:
  - `skip` and `startOfFrame` in the same cycle: `skip` wins.
  - `startOfFrame` and `level_won` in IDLE: enter SLIDE at START_Y; that frame does not move the banner.
- `topLeftX` is constant at TARGET_X except during reset.

## Timing
- Reset values: state IDLE; `topLeftX`=TARGET_X; `topLeftY`=START_Y; `banner_visible`=0; `next_level_req`=0; `busy`=0; `frame_cnt`=0; blink phase=1.
- Reset asserted mid-operation returns every output to its reset value on the next edge; an outstanding request is dropped.
- `level_won` at cycle t gives state SLIDE, `busy`=1 and `banner_visible`=1 at t+1.
- Position updates appear one cycle after `startOfFrame`.
- `next_level_ack` at cycle t gives `next_level_req`=0 and `busy`=0 at t+1. The ack may arrive in the very first REQ cycle.
- Slide duration is ceil((TARGET_Y-START_Y)/SLIDE_STEP) frames. If START_Y ≥ TARGET_Y, HOLD is entered on the first frame.

## Configuration
- `WIN_BANNER_BLINK_EN` defined:
  - In HOLD, the blink phase toggles every BLINK_HALF frames, counted by a dedicated counter cleared on HOLD entry.
  - `banner_visible` = blink phase during HOLD.
  - SLIDE and REQ remain steadily visible.
- Undefined: `banner_visible`=1 throughout SLIDE, HOLD and REQ, and the blink counter logic is absent.

## Test plan
- Reset check: assert reset mid-HOLD -> next cycle IDLE, `topLeftY`=0, `banner_visible`=0, `busy`=0.
- Nominal run with defaults: `level_won`, then frames -> Y steps 0,4,…,212, then 215 after 54 frames. HOLD lasts 120 frames. `next_level_req` rises one cycle after the 120th frame pulse; ack -> IDLE.
- Skip during SLIDE at Y=40 -> next cycle Y=215, HOLD. Skip again -> REQ next cycle.
- Ignore cases: `level_won` during HOLD has no effect; `next_level_ack` in IDLE has no effect; `skip` and `startOfFrame` together in SLIDE -> Y=215, not 44.
- Delayed ack: hold ack low for 500 cycles in REQ -> req stays 1 and visible stays 1. Ack for 1 cycle -> single-cycle exit.
- With `WIN_BANNER_BLINK_EN`, BLINK_HALF=8: visible is 1 for HOLD frames 0–7, 0 for 8–15, 1 for 16–23. Without the macro: constant 1.
